npc_ifu_fetch: RTL and testbench

//  Instruction fetch unit directly upstream of the single-cycle NPC core.

---
 rtl/npc_pkg.sv | 20 ++
 rtl/npc_ifu_fetch.sv | 112 +++++++++++
 tb/tb_npc_ifu_fetch.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared types and constants for the NPC instruction fetch unit
package npc_pkg;

    typedef enum logic [2:0] {
        ST_REQ   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_FAULT = 3'd4
    } ifu_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] EBREAK           = 32'h0010_0073;

    function automatic logic pc_aligned(input logic [31:0] pc_val);
        return pc_val[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/npc_ifu_fetch.sv
// rtl/npc_ifu_fetch.sv - single-outstanding instruction fetch unit feeding the NPC core
module npc_ifu_fetch
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [31:0]      imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    input  logic             imem_rsp_err,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    output logic             fetch_fault,
    output logic [CNT_W-1:0] fetch_cnt
);

    ifu_state_t  state;
    ifu_state_t  state_n;
    logic [31:0] pc;
    logic [31:0] pc_n;
    logic        inst_load;
    logic        inst_take;
    logic        upd_apply;

    assign imem_req_addr = pc;

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        inst_load = 1'b0;
        inst_take = 1'b0;
        upd_apply = 1'b0;
        case (state)
            ST_REQ: begin
                if (imem_req_valid && imem_req_ready) begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        state_n = ST_FAULT;
                    end else begin
                        state_n   = ST_HOLD;
                        inst_load = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (inst_ready) begin
                    inst_take = 1'b1;
                    upd_apply = upd_valid;
                    state_n   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                upd_apply = upd_valid;
            end
            ST_FAULT: begin
                state_n = ST_FAULT;
            end
            default: begin
                state_n = ST_FAULT;
            end
        endcase
        // A misaligned next PC is a fetch fault; the PC keeps its old value.
        if (upd_apply) begin
            if (pc_aligned(upd_pc)) begin
                pc_n    = upd_pc;
                state_n = ST_REQ;
            end else begin
                state_n = ST_FAULT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_REQ;
            pc             <= RESET_PC;
            inst           <= 32'h0;
            inst_pc        <= 32'h0;
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
            fetch_fault    <= 1'b0;
            fetch_cnt      <= '0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            imem_req_valid <= (state_n == ST_REQ);
            inst_valid     <= (state_n == ST_HOLD);
            fetch_fault    <= (state_n == ST_FAULT);
            if (inst_load) begin
                inst    <= imem_rsp_data;
                inst_pc <= pc;
            end
            if (inst_take) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_npc_ifu_fetch.sv
// tb/tb_npc_ifu_fetch.sv - randomized and directed bench for npc_ifu_fetch against a transaction model
module tb_npc_ifu_fetch;
    import npc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        imem_rsp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic        fetch_fault;
    logic [31:0] fetch_cnt;

    int total = 0;
    int bad = 0;

    npc_ifu_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc),
        .fetch_fault(fetch_fault), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: what the fetch unit owes the outside world.
    localparam int P_ASK = 0, P_AWAIT = 1, P_OFFER = 2, P_RUN = 3, P_DEAD = 4;
    int          m_phase = P_ASK;
    logic [31:0] m_pc = RESET_PC_DEFAULT;
    logic [31:0] m_inst = 32'h0;
    logic [31:0] m_ipc = 32'h0;
    logic [31:0] m_acc = 32'h0;
    logic        m_req = 1'b0;
    logic [31:0] cnt_base = 32'h0;

    task automatic model_take_pc();
        if (upd_pc[1:0] == 2'b00) begin
            m_pc    = upd_pc;
            m_phase = P_ASK;
        end else begin
            m_phase = P_DEAD;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = P_ASK;
            m_pc    = RESET_PC_DEFAULT;
            m_inst  = 32'h0;
            m_ipc   = 32'h0;
            m_acc   = 32'h0;
            m_req   = 1'b0;
        end else begin
            if (m_phase == P_ASK && m_req && imem_req_ready) begin
                m_phase = P_AWAIT;
            end else if (m_phase == P_AWAIT && imem_rsp_valid) begin
                if (imem_rsp_err) begin
                    m_phase = P_DEAD;
                end else begin
                    m_inst  = imem_rsp_data;
                    m_ipc   = m_pc;
                    m_phase = P_OFFER;
                end
            end else if (m_phase == P_OFFER && inst_ready) begin
                m_acc = m_acc + 32'd1;
                if (upd_valid) model_take_pc();
                else m_phase = P_RUN;
            end else if (m_phase == P_RUN && upd_valid) begin
                model_take_pc();
            end
            m_req = (m_phase == P_ASK);
        end
    end

    always @(posedge clk) begin
        #2;
        if (rst) begin
            check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
            check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
            check("rst_fetch_cnt", fetch_cnt, 32'h0);
        end else begin
            check("req_valid", {31'h0, imem_req_valid}, {31'h0, m_req});
            if (m_req) check("req_addr", imem_req_addr, m_pc);
            check("inst_valid", {31'h0, inst_valid}, {31'h0, m_phase == P_OFFER});
            check("inst", inst, m_inst);
            check("inst_pc", inst_pc, m_ipc);
            check("fetch_fault", {31'h0, fetch_fault}, {31'h0, m_phase == P_DEAD});
            check("fetch_cnt", fetch_cnt, cnt_base + m_acc);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cnt_base = 32'h0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int dead_cycles;
        logic [31:0] rnd;

        tick();
        tick();
        check("reset_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("reset_inst", inst, 32'h0);
        check("reset_inst_pc", inst_pc, 32'h0);
        check("reset_fault", {31'h0, fetch_fault}, 32'h0);
        check("reset_cnt", fetch_cnt, 32'h0);

        // 1: minimum-latency fetch from the reset PC
        rst = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        check("t1_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("t1_req_addr", imem_req_addr, 32'h8000_0000);
        tick();
        imem_req_ready = 1'b0;
        check("t1_req_dropped", {31'h0, imem_req_valid}, 32'h0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = INST_NOP;
        tick();
        imem_rsp_valid = 1'b0;
        check("t1_inst_valid", {31'h0, inst_valid}, 32'h1);
        check("t1_inst", inst, 32'h0000_0013);
        check("t1_inst_pc", inst_pc, 32'h8000_0000);

        // 2: core stalls; instruction must hold steady
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_inst_valid", {31'h0, inst_valid}, 32'h1);
            check("t2_inst", inst, 32'h0000_0013);
            check("t2_inst_pc", inst_pc, 32'h8000_0000);
            check("t2_no_req", {31'h0, imem_req_valid}, 32'h0);
        end

        // 3: accept with same-cycle next-PC commit
        inst_ready = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h8000_0010;
        tick();
        inst_ready = 1'b0;
        upd_valid  = 1'b0;
        check("t3_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("t3_req_addr", imem_req_addr, 32'h8000_0010);
        check("t3_cnt", fetch_cnt, 32'h1);

        // 4: misaligned next PC faults; reset recovers
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = EBREAK;
        tick();
        imem_rsp_valid = 1'b0;
        check("t4_inst", inst, 32'h0010_0073);
        check("t4_inst_pc", inst_pc, 32'h8000_0010);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("t4_exec_valid", {31'h0, inst_valid}, 32'h0);
        check("t4_cnt", fetch_cnt, 32'h2);
        upd_valid = 1'b1;
        upd_pc    = 32'h8000_0006;
        tick();
        upd_valid = 1'b0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t4_fault", {31'h0, fetch_fault}, 32'h1);
            check("t4_no_req", {31'h0, imem_req_valid}, 32'h0);
            tick();
        end
        imem_req_ready = 1'b0;
        rst = 1'b1;
        cnt_base = 32'h0;
        #1;
        check("t4_fault_cleared", {31'h0, fetch_fault}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("t4_req_after_rst", {31'h0, imem_req_valid}, 32'h1);
        check("t4_addr_after_rst", imem_req_addr, 32'h8000_0000);

        // 5: access fault on the response
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b1;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t5_fault", {31'h0, fetch_fault}, 32'h1);
            check("t5_no_inst", {31'h0, inst_valid}, 32'h0);
            tick();
        end

        // 6: reset during an outstanding read, stale response, counter wrap
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_req_held", {31'h0, imem_req_valid}, 32'h1);
            check("t6_addr_held", imem_req_addr, 32'h8000_0000);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        #1;
        rst = 1'b1;
        cnt_base = 32'h0;
        #1;
        check("t6_async_req", {31'h0, imem_req_valid}, 32'h0);
        check("t6_async_inst_valid", {31'h0, inst_valid}, 32'h0);
        check("t6_async_fault", {31'h0, fetch_fault}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        check("t6_stale_ignored", {31'h0, inst_valid}, 32'h0);
        cnt_base = 32'hFFFF_FFFF;
        force dut.fetch_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = INST_NOP;
        tick();
        imem_rsp_valid = 1'b0;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("t6_cnt_wrap", fetch_cnt, 32'h0);

        // randomized traffic
        do_reset();
        dead_cycles = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (rst) begin
                rst = 1'b0;
                continue;
            end
            dead_cycles = (m_phase == P_DEAD) ? dead_cycles + 1 : 0;
            if (dead_cycles > 6 || $urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                cnt_base = 32'h0;
                dead_cycles = 0;
            end
            imem_req_ready = ($urandom_range(0, 2) != 0);
            imem_rsp_valid = ($urandom_range(0, 2) == 0);
            imem_rsp_data  = $urandom;
            imem_rsp_err   = ($urandom_range(0, 39) == 0);
            inst_ready     = ($urandom_range(0, 1) == 1);
            upd_valid      = ($urandom_range(0, 2) == 0);
            rnd            = $urandom;
            upd_pc         = ($urandom_range(0, 19) == 0) ? (rnd | 32'h1) : {rnd[31:2], 2'b00};
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
